// File: rtl/compare_lt_iter.sv
// Iterative less-than / less-or-equal comparator, CHUNK bits per cycle, MSB chunk first.
// Optional COMPARE_LT_EARLY_EXIT_EN: finish at the first differing chunk instead of after all chunks.
module compare_lt_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             is_equal,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic             r_is_equal;
    logic             r_found;
    logic             r_result;
    logic [IDXW-1:0]  r_idx;

    logic [WIDTH-1:0] w_bias;
    logic [31:0]      w_shamt;
    logic [WIDTH-1:0] w_sh1;
    logic [WIDTH-1:0] w_sh2;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic             w_first_diff;
    logic             w_last;
    logic             w_accept;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_bias       = {is_signed, {(WIDTH-1){1'b0}}};
    assign w_shamt      = 32'(r_idx) * 32'(CHUNK);
    assign w_sh1        = r_op1 >> w_shamt;
    assign w_sh2        = r_op2 >> w_shamt;
    assign w_a          = w_sh1[CHUNK-1:0];
    assign w_b          = w_sh2[CHUNK-1:0];
    assign w_first_diff = (w_a != w_b) && !r_found;
    assign w_last       = (r_idx == '0);
    assign w_accept     = (r_state == IDLE) && in_valid && !flush;
    assign result       = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
`ifdef COMPARE_LT_EARLY_EXIT_EN
                if (w_first_diff || w_last) begin
                    w_state_nxt = DONE;
                end
`else
                if (w_last) begin
                    w_state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Abort wins over both accept and completion.
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 1'b0;
            r_found  <= 1'b0;
            r_idx    <= '0;
        end else if (!flush) begin
            if (w_accept) begin
                r_found <= 1'b0;
                r_idx   <= IDX_LAST;
            end else if (r_state == BUSY) begin
                if (w_first_diff) begin
                    r_result <= (w_a < w_b);
                    r_found  <= 1'b1;
                end else if (w_last && !r_found) begin
                    r_result <= r_is_equal;
                end
                if (!w_last) begin
                    r_idx <= r_idx - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op1      <= data1 ^ w_bias;
            r_op2      <= data2 ^ w_bias;
            r_is_equal <= is_equal;
        end
    end

endmodule
